// File: rtl/id_decode_stage_if.sv
// IF/ID, EX-feedback, write-back and ID/EX signal bundle for the decode stage.
// The slave modport is the decode stage itself; the master modport is whoever
// drives the fetch side and consumes the ID/EX register.
interface id_decode_stage_if #(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
);
  logic               i_valid;
  logic               o_ready;
  logic [NB_ADDR-1:0] i_pc;
  logic [NB_INST-1:0] i_instruction;
  logic               i_flush;
  logic               i_ex_ready;
  logic               i_ex_memread;
  logic [NB_REG-1:0]  i_ex_rt;
  logic               i_wb_en;
  logic [NB_REG-1:0]  i_wb_addr;
  logic [NB_DATA-1:0] i_wb_data;
  logic               o_valid;
  logic [NB_ADDR-1:0] o_pc;
  logic [NB_INST-1:0] o_instruction;
  logic [5:0]         o_opcode;
  logic [5:0]         o_funct;
  logic [NB_REG-1:0]  o_rs;
  logic [NB_REG-1:0]  o_rt;
  logic [NB_REG-1:0]  o_rd;
  logic [NB_REG-1:0]  o_shamt;
  logic [NB_DATA-1:0] o_immediate;
  logic [NB_DATA-1:0] o_rs_data;
  logic [NB_DATA-1:0] o_rt_data;
  logic               o_stall;

  modport slave (
    input  i_valid, i_pc, i_instruction, i_flush, i_ex_ready, i_ex_memread,
           i_ex_rt, i_wb_en, i_wb_addr, i_wb_data,
    output o_ready, o_valid, o_pc, o_instruction, o_opcode, o_funct, o_rs,
           o_rt, o_rd, o_shamt, o_immediate, o_rs_data, o_rt_data, o_stall
  );

  modport master (
    output i_valid, i_pc, i_instruction, i_flush, i_ex_ready, i_ex_memread,
           i_ex_rt, i_wb_en, i_wb_addr, i_wb_data,
    input  o_ready, o_valid, o_pc, o_instruction, o_opcode, o_funct, o_rs,
           o_rt, o_rd, o_shamt, o_immediate, o_rs_data, o_rt_data, o_stall
  );
endinterface

// File: rtl/id_decode_stage.sv
// Pipelined MIPS instruction-decode stage: valid/ready intake from IF/ID,
// field decode, opcode-dependent immediate extension, register file with
// write-back bypass, load-use hazard detection and a registered ID/EX stage
// with backpressure and flush.
module id_decode_stage #(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32
) (
  input logic                i_clk,
  input logic                i_rst_n,
  id_decode_stage_if.slave   bus
);

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  // Register-file depth expressed at index width + 1 so out-of-range indices compare cleanly
  localparam logic [NB_REG:0] N_REGS_LIM = (NB_REG + 1)'(N_REGS);

  logic [NB_DATA-1:0] regs_q [N_REGS];
  logic [NB_DATA-1:0] regs_d [N_REGS];

  logic               valid_q, valid_d;
  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic [NB_INST-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] imm_q, imm_d;
  logic [NB_DATA-1:0] rs_data_q, rs_data_d;
  logic [NB_DATA-1:0] rt_data_q, rt_data_d;

  logic [5:0]         in_opcode;
  logic [NB_REG-1:0]  in_rs;
  logic [NB_REG-1:0]  in_rt;
  logic [15:0]        in_imm;
  logic [NB_DATA-1:0] in_imm_ext;
  logic [NB_DATA-1:0] rs_read;
  logic [NB_DATA-1:0] rt_read;
  logic               wb_write;
  logic               hazard;
  logic               out_free;
  logic               ready;
  logic               accept;

  assign in_opcode = bus.i_instruction[31:26];
  assign in_rs     = NB_REG'(bus.i_instruction[25:21]);
  assign in_rt     = NB_REG'(bus.i_instruction[20:16]);
  assign in_imm    = bus.i_instruction[15:0];

  assign wb_write = bus.i_wb_en && (bus.i_wb_addr != '0) &&
                    ({1'b0, bus.i_wb_addr} < N_REGS_LIM);

  assign hazard   = bus.i_valid && bus.i_ex_memread && (bus.i_ex_rt != '0) &&
                    ((bus.i_ex_rt == in_rs) || (bus.i_ex_rt == in_rt));
  assign out_free = !valid_q || bus.i_ex_ready;
  assign ready    = !bus.i_flush && !hazard && out_free;
  assign accept   = bus.i_valid && ready;

  // Extend the 16-bit immediate: logical ops zero-extend, LUI shifts up, everything else sign-extends
  always_comb begin
    in_imm_ext = {{(NB_DATA-16){in_imm[15]}}, in_imm};
    case (in_opcode)
      OP_ANDI, OP_ORI, OP_XORI: in_imm_ext = {{(NB_DATA-16){1'b0}}, in_imm};
      OP_LUI:                   in_imm_ext = {in_imm, {(NB_DATA-16){1'b0}}};
      default:                  in_imm_ext = {{(NB_DATA-16){in_imm[15]}}, in_imm};
    endcase
  end

  // Register reads: r0 and out-of-range indices read zero, a same-cycle write-back wins over the array
  always_comb begin
    rs_read = '0;
    rt_read = '0;
    if ((in_rs != '0) && ({1'b0, in_rs} < N_REGS_LIM)) begin
      if (bus.i_wb_en && (bus.i_wb_addr == in_rs)) rs_read = bus.i_wb_data;
      else                                          rs_read = regs_q[in_rs];
    end
    if ((in_rt != '0) && ({1'b0, in_rt} < N_REGS_LIM)) begin
      if (bus.i_wb_en && (bus.i_wb_addr == in_rt)) rt_read = bus.i_wb_data;
      else                                          rt_read = regs_q[in_rt];
    end
  end

  // Next register-file contents: write-back lands regardless of flush or stall
  always_comb begin
    regs_d = regs_q;
    if (wb_write) regs_d[bus.i_wb_addr] = bus.i_wb_data;
  end

  // ID/EX next state: flush kills, accept loads, an empty slot becomes a bubble, a stalled full slot holds
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    if (out_free || bus.i_flush) begin
      if (bus.i_flush) begin
        valid_d = 1'b0;
      end else if (accept) begin
        valid_d   = 1'b1;
        pc_d      = bus.i_pc;
        instr_d   = bus.i_instruction;
        imm_d     = in_imm_ext;
        rs_data_d = rs_read;
        rt_data_d = rt_read;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Register file storage, cleared by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_stall       = hazard;
  assign bus.o_valid       = valid_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_instruction = instr_q;
  assign bus.o_opcode      = instr_q[31:26];
  assign bus.o_funct       = instr_q[5:0];
  assign bus.o_rs          = NB_REG'(instr_q[25:21]);
  assign bus.o_rt          = NB_REG'(instr_q[20:16]);
  assign bus.o_rd          = NB_REG'(instr_q[15:11]);
  assign bus.o_shamt       = NB_REG'(instr_q[10:6]);
  assign bus.o_immediate   = imm_q;
  assign bus.o_rs_data     = rs_data_q;
  assign bus.o_rt_data     = rt_data_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_id_decode_stage;

  localparam int NB_ADDR = 32;
  localparam int NB_INST = 32;
  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int N_REGS  = 32;

  logic clk = 1'b0;
  logic rst_n;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  bit          m_valid;
  logic [31:0] m_pc, m_instr, m_imm, m_rs_data, m_rt_data;
  logic [31:0] mreg [32];

  logic [31:0] saved_instr, saved_pc, saved_imm;

  id_decode_stage_if #(.NB_ADDR(NB_ADDR), .NB_INST(NB_INST), .NB_DATA(NB_DATA),
                       .NB_REG(NB_REG)) bus ();

  id_decode_stage #(.NB_ADDR(NB_ADDR), .NB_INST(NB_INST), .NB_DATA(NB_DATA),
                    .NB_REG(NB_REG), .N_REGS(N_REGS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mkR(input int rs, input int rt, input int rd,
                                      input int shamt, input int funct);
    mkR = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(shamt), 6'(funct)};
  endfunction

  function automatic logic [31:0] mkI(input int op, input int rs, input int rt,
                                      input int imm);
    mkI = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Immediate as the ISA defines it
  function automatic logic [31:0] expImm(input logic [31:0] ins);
    int op;
    int imm;
    op  = int'(ins[31:26]);
    imm = int'(ins[15:0]);
    if (op == 'h0C || op == 'h0D || op == 'h0E) return 32'(imm);
    if (op == 'h0F) return 32'(imm * 65536);
    if (imm >= 32768) return 32'(imm - 65536);
    return 32'(imm);
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bus.i_wb_en && bus.i_wb_addr == idx) return bus.i_wb_data;
    return mreg[idx];
  endfunction

  function automatic bit expHazard();
    return bus.i_valid && bus.i_ex_memread && (bus.i_ex_rt != 0) &&
           (bus.i_ex_rt == bus.i_instruction[25:21] ||
            bus.i_ex_rt == bus.i_instruction[20:16]);
  endfunction

  function automatic bit expReady();
    return !bus.i_flush && !expHazard() && (!m_valid || bus.i_ex_ready);
  endfunction

  task automatic modelReset();
    m_valid = 0;
    m_pc = 0; m_instr = 0; m_imm = 0; m_rs_data = 0; m_rt_data = 0;
    for (int i = 0; i < 32; i++) mreg[i] = 0;
  endtask

  // Drive one cycle of inputs (called at the falling edge) and check the combinational outputs
  task automatic applyStimulus(input bit valid, input logic [31:0] pc,
                               input logic [31:0] instr, input bit flush,
                               input bit ex_ready, input bit memread,
                               input logic [4:0] ex_rt, input bit wb_en,
                               input logic [4:0] wb_addr, input logic [31:0] wb_data);
    bus.i_valid       = valid;
    bus.i_pc          = pc;
    bus.i_instruction = instr;
    bus.i_flush       = flush;
    bus.i_ex_ready    = ex_ready;
    bus.i_ex_memread  = memread;
    bus.i_ex_rt       = ex_rt;
    bus.i_wb_en       = wb_en;
    bus.i_wb_addr     = wb_addr;
    bus.i_wb_data     = wb_data;
    #1;
    checkOutput("stall", 64'(bus.o_stall), 64'(expHazard()));
    checkOutput("ready", 64'(bus.o_ready), 64'(expReady()));
  endtask

  // Compare every registered output with the model
  task automatic checkRegs();
    checkOutput("valid", 64'(bus.o_valid), 64'(m_valid));
    if (m_valid) begin
      checkOutput("pc", 64'(bus.o_pc), 64'(m_pc));
      checkOutput("instruction", 64'(bus.o_instruction), 64'(m_instr));
      checkOutput("opcode", 64'(bus.o_opcode), 64'(m_instr[31:26]));
      checkOutput("funct", 64'(bus.o_funct), 64'(m_instr[5:0]));
      checkOutput("rs", 64'(bus.o_rs), 64'(m_instr[25:21]));
      checkOutput("rt", 64'(bus.o_rt), 64'(m_instr[20:16]));
      checkOutput("rd", 64'(bus.o_rd), 64'(m_instr[15:11]));
      checkOutput("shamt", 64'(bus.o_shamt), 64'(m_instr[10:6]));
      checkOutput("immediate", 64'(bus.o_immediate), 64'(m_imm));
      checkOutput("rs_data", 64'(bus.o_rs_data), 64'(m_rs_data));
      checkOutput("rt_data", 64'(bus.o_rt_data), 64'(m_rt_data));
    end
  endtask

  // Advance the model across one rising edge and check the result at the next falling edge
  task automatic clockCycle();
    bit          acc, n_valid;
    logic [31:0] n_pc, n_instr, n_imm, n_rs, n_rt;
    acc     = bus.i_valid && expReady();
    n_valid = m_valid;
    n_pc = m_pc; n_instr = m_instr; n_imm = m_imm; n_rs = m_rs_data; n_rt = m_rt_data;
    if (!m_valid || bus.i_ex_ready || bus.i_flush) begin
      if (bus.i_flush) n_valid = 0;
      else if (acc) begin
        n_valid = 1;
        n_pc    = bus.i_pc;
        n_instr = bus.i_instruction;
        n_imm   = expImm(bus.i_instruction);
        n_rs    = modelRead(bus.i_instruction[25:21]);
        n_rt    = modelRead(bus.i_instruction[20:16]);
      end else n_valid = 0;
    end
    @(posedge clk);
    if (bus.i_wb_en && bus.i_wb_addr != 0) mreg[bus.i_wb_addr] = bus.i_wb_data;
    m_valid = n_valid; m_pc = n_pc; m_instr = n_instr; m_imm = n_imm;
    m_rs_data = n_rs; m_rt_data = n_rt;
    @(negedge clk);
    checkRegs();
  endtask

  // Shorthand for a plain instruction with no hazards, write-back or flush
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    applyStimulus(1, pc, instr, 0, 1, 0, 0, 0, 0, 0);
    clockCycle();
  endtask

  task automatic writeBack(input logic [4:0] addr, input logic [31:0] data);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, addr, data);
    clockCycle();
  endtask

  logic [31:0] add_instr;
  int          opsel;
  logic [5:0]  rop;

  initial begin
    add_instr = mkR(2, 1, 0, 0, 'h20);
    rst_n = 1'b0;
    bus.i_valid = 0; bus.i_pc = 0; bus.i_instruction = 0; bus.i_flush = 0;
    bus.i_ex_ready = 0; bus.i_ex_memread = 0; bus.i_ex_rt = 0;
    bus.i_wb_en = 0; bus.i_wb_addr = 0; bus.i_wb_data = 0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("rst_pc", 64'(bus.o_pc), 64'd0);
    checkOutput("rst_immediate", 64'(bus.o_immediate), 64'd0);
    checkOutput("rst_rs_data", 64'(bus.o_rs_data), 64'd0);

    // First ADD with an empty register file
    issue(32'd1, add_instr);
    checkOutput("add_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("add_rs", 64'(bus.o_rs), 64'd2);
    checkOutput("add_rt", 64'(bus.o_rt), 64'd1);
    checkOutput("add_rd", 64'(bus.o_rd), 64'd0);
    checkOutput("add_funct", 64'(bus.o_funct), 64'h20);
    checkOutput("add_pc", 64'(bus.o_pc), 64'd1);
    checkOutput("add_rs_data0", 64'(bus.o_rs_data), 64'd0);
    checkOutput("add_rt_data0", 64'(bus.o_rt_data), 64'd0);

    // Register reads after write-back, then same-cycle bypass, then r0 protection
    writeBack(5'd2, 32'd5);
    writeBack(5'd1, 32'd7);
    issue(32'd2, add_instr);
    checkOutput("rf_rs_data", 64'(bus.o_rs_data), 64'd5);
    checkOutput("rf_rt_data", 64'(bus.o_rt_data), 64'd7);
    applyStimulus(1, 32'd3, add_instr, 0, 1, 0, 0, 1, 5'd2, 32'd9);
    clockCycle();
    checkOutput("bypass_rs_data", 64'(bus.o_rs_data), 64'd9);
    writeBack(5'd0, 32'hFFFF);
    issue(32'd4, mkR(0, 1, 3, 0, 'h20));
    checkOutput("r0_reads_zero", 64'(bus.o_rs_data), 64'd0);

    // Immediate extension
    issue(32'd5, mkI('h08, 1, 4, 'hFFFC));
    checkOutput("addi_imm", 64'(bus.o_immediate), 64'hFFFFFFFC);
    issue(32'd6, mkI('h0D, 1, 4, 'h8000));
    checkOutput("ori_imm", 64'(bus.o_immediate), 64'h00008000);
    issue(32'd7, mkI('h0F, 0, 4, 'h1234));
    checkOutput("lui_imm", 64'(bus.o_immediate), 64'h12340000);

    // Load-use hazard, then release
    applyStimulus(1, 32'd8, add_instr, 0, 1, 1, 5'd2, 0, 0, 0);
    checkOutput("lu_stall", 64'(bus.o_stall), 64'd1);
    checkOutput("lu_ready", 64'(bus.o_ready), 64'd0);
    clockCycle();
    checkOutput("lu_bubble", 64'(bus.o_valid), 64'd0);
    issue(32'd8, add_instr);
    checkOutput("lu_release_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("lu_release_pc", 64'(bus.o_pc), 64'd8);

    // Backpressure: three stalled cycles, then release
    saved_instr = bus.o_instruction;
    saved_pc    = bus.o_pc;
    saved_imm   = bus.o_immediate;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'd9, mkI('h08, 1, 2, 'h0042), 0, 0, 0, 0, 0, 0, 0);
      checkOutput("bp_ready", 64'(bus.o_ready), 64'd0);
      clockCycle();
      checkOutput("bp_hold_instr", 64'(bus.o_instruction), 64'(saved_instr));
      checkOutput("bp_hold_pc", 64'(bus.o_pc), 64'(saved_pc));
      checkOutput("bp_hold_imm", 64'(bus.o_immediate), 64'(saved_imm));
    end
    applyStimulus(1, 32'd9, mkI('h08, 1, 2, 'h0042), 0, 1, 0, 0, 0, 0, 0);
    checkOutput("bp_release_ready", 64'(bus.o_ready), 64'd1);
    clockCycle();
    checkOutput("bp_release_pc", 64'(bus.o_pc), 64'd9);
    checkOutput("bp_release_imm", 64'(bus.o_immediate), 64'h42);

    // Flush with a concurrent hazard and write-back; instruction must not be taken
    applyStimulus(1, 32'd10, mkR(3, 0, 5, 0, 'h20), 1, 0, 1, 5'd3, 1, 5'd3, 32'h33);
    checkOutput("flush_ready", 64'(bus.o_ready), 64'd0);
    checkOutput("flush_stall", 64'(bus.o_stall), 64'd1);
    clockCycle();
    checkOutput("flush_valid", 64'(bus.o_valid), 64'd0);
    issue(32'd11, mkR(3, 0, 5, 0, 'h20));
    checkOutput("flush_wb_kept", 64'(bus.o_rs_data), 64'h33);
    checkOutput("flush_next_pc", 64'(bus.o_pc), 64'd11);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      opsel = $urandom_range(0, 7);
      case (opsel)
        0: rop = 6'h00; 1: rop = 6'h08; 2: rop = 6'h0C; 3: rop = 6'h0D;
        4: rop = 6'h0E; 5: rop = 6'h0F; 6: rop = 6'h23;
        default: rop = 6'($urandom);
      endcase
      applyStimulus($urandom_range(0, 9) < 8, $urandom,
                    {rop, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)},
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 3, 5'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)), $urandom);
      clockCycle();
    end

    // Mid-stream asynchronous reset
    issue(32'd12, add_instr);
    checkOutput("pre_reset_valid", 64'(bus.o_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("async_reset_pc", 64'(bus.o_pc), 64'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd13, mkR(2, 1, 0, 0, 'h20));
    checkOutput("reset_cleared_rs", 64'(bus.o_rs_data), 64'd0);
    checkOutput("reset_cleared_rt", 64'(bus.o_rt_data), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
